// File: rtl/tpu_seq_ctrl.sv
// Purpose: byte-serial command sequencer feeding an N x N systolic MAC array and serialising its results.
// Latency: array-side strobes appear one cycle after the accepting cmd handshake; result bytes stream from the cycle after READ.
// Backpressure: cmd_ready drops during DRAIN and RD; out_byte holds while out_ready is low.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_byte    command/data byte input handshake
//   w_we, w_idx, w_byte             registered weight write port (row-major index)
//   acc_clr                         registered one-cycle accumulator clear
//   act_valid, act_vec              registered activation vector strobe (byte i at [8*i+:8])
//   drain                           registered array drain enable
//   acc_in                          array results (result j at [ACC_W*j+:ACC_W])
//   out_valid/out_ready/out_byte    result byte output handshake (result 0 first, LSB-first)
//   busy, done                      not-idle flag, one-cycle end-of-RUN pulse

module tpu_seq_ctrl #(
  parameter int N         = 2,
  parameter int ACC_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_byte,
  output logic                   w_we,
  output logic [$clog2(N*N)-1:0] w_idx,
  output logic [7:0]             w_byte,
  output logic                   acc_clr,
  output logic                   act_valid,
  output logic [8*N-1:0]         act_vec,
  output logic                   drain,
  input  logic [N*ACC_W-1:0]     acc_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   busy,
  output logic                   done
);

  localparam int NW  = N * N;
  localparam int WIW = $clog2(NW);
  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int NB  = N * ACC_W / 8;
  localparam int RBW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DCW = $clog2(DRAIN_CYC + 1);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDW  = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_W,
    S_LD_A,
    S_DRAIN,
    S_RD
  } state_t;

  state_t               state_q, state_d;
  logic [WIW-1:0]       w_cnt_q;
  logic [PW-1:0]        pos_q;
  logic [5:0]           vec_cnt_q;
  logic [8*N-1:0]       vbuf_q;
  logic [DCW-1:0]       drn_cnt_q;
  logic [RBW-1:0]       rd_cnt_q;
  logic [N*ACC_W-1:0]   snap_q;

  logic                 accept;
  logic                 rd_xfer;
  logic [1:0]           op;
  logic [5:0]           len;
  logic                 w_last;
  logic                 vec_end;
  logic                 vec_last;
  logic                 drn_end;
  logic                 rd_last;
  logic [8*N-1:0]       vec_next;

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_LD_W) || (state_q == S_LD_A);
  assign out_valid = (state_q == S_RD);
  assign out_byte  = snap_q[7:0];
  assign busy      = (state_q != S_IDLE);

  assign accept   = cmd_valid && cmd_ready;
  assign rd_xfer  = out_valid && out_ready;
  assign op       = cmd_byte[7:6];
  assign len      = cmd_byte[5:0];
  assign w_last   = (w_cnt_q == WIW'(NW - 1));
  assign vec_end  = (pos_q == PW'(N - 1));
  assign vec_last = vec_end && (vec_cnt_q == 6'd1);
  assign drn_end  = (drn_cnt_q == DCW'(DRAIN_CYC));
  assign rd_last  = (rd_cnt_q == RBW'(NB - 1));

  // Vector under construction with the current byte merged in; used both to
  // keep packing and to launch the completed vector without a stall cycle.
  always_comb begin
    vec_next = vbuf_q;
    vec_next[8*int'(pos_q) +: 8] = cmd_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_LDW:  state_d = S_LD_W;
            OP_RUN:  state_d = (len != 6'd0) ? S_LD_A : S_IDLE;
            OP_READ: state_d = S_RD;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LD_W:  if (accept && w_last)   state_d = S_IDLE;
      S_LD_A:  if (accept && vec_last) state_d = S_DRAIN;
      S_DRAIN: if (drn_end)            state_d = S_IDLE;
      S_RD:    if (rd_xfer && rd_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_we      <= 1'b0;
      w_idx     <= '0;
      w_byte    <= '0;
      acc_clr   <= 1'b0;
      act_valid <= 1'b0;
      act_vec   <= '0;
      drain     <= 1'b0;
      done      <= 1'b0;
      w_cnt_q   <= '0;
      pos_q     <= '0;
      vec_cnt_q <= '0;
      vbuf_q    <= '0;
      drn_cnt_q <= '0;
      rd_cnt_q  <= '0;
      snap_q    <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      w_we      <= 1'b0;
      acc_clr   <= 1'b0;
      act_valid <= 1'b0;
      drain     <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_LDW: w_cnt_q <= '0;
              OP_RUN: begin
                if (len != 6'd0) begin
                  acc_clr   <= 1'b1;
                  vec_cnt_q <= len;
                  pos_q     <= '0;
                end
              end
              OP_READ: begin
                snap_q   <= acc_in;
                rd_cnt_q <= '0;
              end
              default: ;
            endcase
          end
        end
        S_LD_W: begin
          if (accept) begin
            w_we    <= 1'b1;
            w_idx   <= w_cnt_q;
            w_byte  <= cmd_byte;
            w_cnt_q <= w_cnt_q + WIW'(1);
          end
        end
        S_LD_A: begin
          if (accept) begin
            if (vec_end) begin
              act_valid <= 1'b1;
              act_vec   <= vec_next;
              vec_cnt_q <= vec_cnt_q - 6'd1;
              pos_q     <= '0;
              drn_cnt_q <= '0;
            end else begin
              vbuf_q <= vec_next;
              pos_q  <= pos_q + PW'(1);
            end
          end
        end
        S_DRAIN: begin
          // The first DRAIN cycle coincides with the last act_valid, so the
          // registered drain starts one cycle later and runs DRAIN_CYC cycles.
          if (drn_end) begin
            done <= 1'b1;
          end else begin
            drain     <= 1'b1;
            drn_cnt_q <= drn_cnt_q + DCW'(1);
          end
        end
        S_RD: begin
          if (rd_xfer) begin
            snap_q   <= snap_q >> 8;
            rd_cnt_q <= rd_cnt_q + RBW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
module tb_tpu_seq_ctrl;

  localparam int N         = 2;
  localparam int ACC_W     = 16;
  localparam int DRAIN_CYC = 3;
  localparam int NW        = N * N;
  localparam int NB        = N * ACC_W / 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [7:0]             cmd_byte;
  logic                   w_we;
  logic [$clog2(NW)-1:0]  w_idx;
  logic [7:0]             w_byte;
  logic                   acc_clr;
  logic                   act_valid;
  logic [8*N-1:0]         act_vec;
  logic                   drain;
  logic [N*ACC_W-1:0]     acc_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_byte;
  logic                   busy;
  logic                   done;

  tpu_seq_ctrl #(.N(N), .ACC_W(ACC_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
    .w_we(w_we), .w_idx(w_idx), .w_byte(w_byte),
    .acc_clr(acc_clr), .act_valid(act_valid), .act_vec(act_vec), .drain(drain),
    .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: expectations pushed by the stimulus side, popped by the monitor.
  logic [15:0]    w_q[$];
  logic [8*N-1:0] a_q[$];
  logic [7:0]     o_q[$];
  int exp_clr = 0, obs_clr = 0;
  int exp_done = 0, obs_done = 0;
  bit gaps = 1'b0;

  logic       prev_act, prev_drain, prev_ostall;
  logic [7:0] prev_ob;
  int         drain_run;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_act = 1'b0; prev_drain = 1'b0; prev_ostall = 1'b0; prev_ob = '0; drain_run = 0;
    end else begin
      if (w_we) begin
        if (w_q.size() == 0) chk("w_we_unexpected", 1, 0);
        else chk("w_idx_byte", {8'(w_idx), w_byte}, w_q.pop_front());
      end
      if (act_valid) begin
        if (a_q.size() == 0) chk("act_valid_unexpected", 1, 0);
        else chk("act_vec", act_vec, a_q.pop_front());
      end
      if (acc_clr) obs_clr++;
      if (done) begin
        obs_done++;
        chk("done_after_drain", {prev_drain, drain}, 2'b10);
      end
      if (drain && !prev_drain) chk("drain_after_act", prev_act, 1);
      if (drain) begin
        drain_run++;
        chk("cmd_ready_in_drain", cmd_ready, 0);
      end else if (prev_drain) begin
        chk("drain_len", drain_run, DRAIN_CYC);
        drain_run = 0;
      end
      if (out_valid) begin
        chk("cmd_ready_in_rd", cmd_ready, 0);
        if (prev_ostall) chk("out_hold", out_byte, prev_ob);
        if (out_ready) begin
          if (o_q.size() == 0) chk("out_unexpected", 1, 0);
          else chk("out_byte", out_byte, o_q.pop_front());
        end
      end
      prev_ostall = out_valid && !out_ready;
      prev_ob     = out_byte;
      prev_act    = act_valid;
      prev_drain  = drain;
    end
  end

  task automatic send(input logic [7:0] b);
    int  waited = 0;
    bit  ok;
    if (gaps && $urandom_range(0, 3) == 0) begin
      cmd_valid = 1'b0;
      cmd_byte  = 8'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b1;
    cmd_byte  = b;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      waited++;
    end while (!ok && waited < 100);
    if (!ok) chk("cmd_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_byte  = 8'($urandom);
  endtask

  task automatic wait_idle(input string nm);
    int waited = 0;
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (busy) chk(nm, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic load_w(input bit directed);
    logic [7:0] b[NW];
    for (int i = 0; i < NW; i++) begin
      b[i] = directed ? 8'(i + 1) : 8'($urandom);
      w_q.push_back({8'(i), b[i]});
    end
    send(8'h40);
    for (int i = 0; i < NW; i++) send(b[i]);
    @(negedge clk);
    chk("busy_after_load", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run(input int len, input bit directed);
    logic [7:0]     bq[$];
    logic [8*N-1:0] vec;
    logic [7:0]     b;
    for (int v = 0; v < len; v++) begin
      vec = '0;
      for (int i = 0; i < N; i++) begin
        b = directed ? 8'(5 + v * N + i) : 8'($urandom);
        vec[8*i +: 8] = b;
        bq.push_back(b);
      end
      a_q.push_back(vec);
    end
    if (len > 0) begin
      exp_clr++;
      exp_done++;
    end
    send({2'b10, 6'(len)});
    foreach (bq[k]) send(bq[k]);
    wait_idle("run_timeout");
  endtask

  task automatic do_read(input logic [N*ACC_W-1:0] val, input bit directed);
    int k = 0, stall = 0, waited = 0;
    acc_in = val;
    for (int i = 0; i < NB; i++) o_q.push_back(val[8*i +: 8]);
    send(8'hC0);
    acc_in = {$urandom, $urandom};
    while (k < NB && waited < 200) begin
      if (directed && k == 1 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = directed ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (out_valid && out_ready) k++;
      waited++;
      @(posedge clk); #1;
    end
    if (k < NB) chk("read_timeout", k, NB);
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_read", {out_valid, busy}, 2'b00);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ready_busy"}, {cmd_ready, busy}, 2'b10);
    chk({nm, "_strobes"}, {w_we, acc_clr, act_valid, drain, out_valid, done}, 6'b0);
    chk({nm, "_data"}, {8'(w_idx), w_byte, 16'(act_vec), out_byte}, 40'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    acc_in    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the block's defining scenarios.
    load_w(1'b1);
    run(2, 1'b1);
    do_read(32'h1234_ABCD, 1'b1);
    send(8'h80);
    send(8'h00);
    @(negedge clk);
    chk("busy_after_nop", busy, 0);
    @(posedge clk); #1;

    // Reset mid-vector: the partial vector must never reach the array.
    exp_clr++;
    send(8'h81);
    send(8'h05);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_w(1'b1);

    // Randomised command mix with idle gaps between bytes.
    gaps = 1'b1;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: send({2'b00, 6'($urandom)});
        1: load_w(1'b0);
        2: run($urandom_range(0, 5), 1'b0);
        3: do_read({$urandom, $urandom}, 1'b0);
        default: begin
          run($urandom_range(1, 4), 1'b0);
          do_read({$urandom, $urandom}, 1'b0);
        end
      endcase
    end

    repeat (10) @(posedge clk);
    chk("w_q_empty", w_q.size(), 0);
    chk("a_q_empty", a_q.size(), 0);
    chk("o_q_empty", o_q.size(), 0);
    chk("acc_clr_count", obs_clr, exp_clr);
    chk("done_count", obs_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
